// File: rtl/tdp_ram_strb.sv
`default_nettype none
// ============================================================================
// Module   : tdp_ram_strb
// Purpose  : True dual-port byte-strobed RAM with 1- or 2-cycle read latency,
//            read-during-write mode select, out-of-range guard and collision
//            flag. Optional macro TDP_RAM_COLL_CNT_EN adds a saturating
//            16-bit collision counter output (coll_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tdp_ram_strb #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [STRB_WIDTH-1:0] wena,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  valida,
    output logic                  oora,
    input  logic                  enb,
    input  logic [STRB_WIDTH-1:0] wenb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  validb,
    output logic                  oorb,
`ifdef TDP_RAM_COLL_CNT_EN
    output logic [15:0]           coll_cnt,
`endif
    output logic                  collision
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [1:0]            w_en;
    logic [1:0]            w_in;
    logic                  w_same;
    logic [STRB_WIDTH-1:0] w_sa;
    logic [STRB_WIDTH-1:0] w_sb;
    logic [DATA_WIDTH-1:0] w_old [2];
    logic [DATA_WIDTH-1:0] w_fin [2];
    logic [DATA_WIDTH-1:0] w_rd  [2];
    logic                  collision_d;
    logic                  collision_q;

    logic [1:0]            v1_q;
    logic [1:0]            o1_q;
    logic [DATA_WIDTH-1:0] d1_q [2];

    logic [1:0]            w_vo;
    logic [1:0]            w_oo;
    logic [DATA_WIDTH-1:0] w_do [2];

    // Byte merge where hi strobes take precedence over lo strobes.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] hi_d,
        input logic [STRB_WIDTH-1:0] hi_s,
        input logic [DATA_WIDTH-1:0] lo_d,
        input logic [STRB_WIDTH-1:0] lo_s
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (hi_s[i])      r[8*i +: 8] = hi_d[8*i +: 8];
            else if (lo_s[i]) r[8*i +: 8] = lo_d[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        w_en        = {enb, ena};
        w_in[0]     = (32'(addra) < MEM_DEPTH);
        w_in[1]     = (32'(addrb) < MEM_DEPTH);
        w_sa        = (ena && w_in[0]) ? wena : '0;
        w_sb        = (enb && w_in[1]) ? wenb : '0;
        w_same      = ena & enb & w_in[0] & w_in[1] & (addra == addrb);
        collision_d = w_same & ((|wena) | (|wenb));
        w_old[0]    = w_in[0] ? mem_q[addra] : '0;
        w_old[1]    = w_in[1] ? mem_q[addrb] : '0;
        // Post-write word as it will sit in memory, port A winning shared bytes.
        w_fin[0]    = merge_bytes(w_old[0], dina, w_sa, dinb, w_same ? w_sb : '0);
        w_fin[1]    = merge_bytes(w_old[1], dina, w_same ? w_sa : '0, dinb, w_sb);
        w_rd[0]     = (RDW_MODE == 1 && (|w_sa)) ? w_fin[0] : w_old[0];
        w_rd[1]     = (RDW_MODE == 1 && (|w_sb)) ? w_fin[1] : w_old[1];
    end

    // Port A is written last so it overrides port B on shared bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_sb[i]) mem_q[addrb][8*i +: 8] <= dinb[8*i +: 8];
            if (w_sa[i]) mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q        <= '0;
            o1_q        <= '0;
            d1_q[0]     <= '0;
            d1_q[1]     <= '0;
            collision_q <= 1'b0;
        end else begin
            v1_q        <= w_en;
            collision_q <= collision_d;
            for (int p = 0; p < 2; p++) begin
                if (w_en[p]) begin
                    d1_q[p] <= w_rd[p];
                    o1_q[p] <= ~w_in[p];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0]            v2_q;
            logic [1:0]            o2_q;
            logic [DATA_WIDTH-1:0] d2_q [2];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v2_q    <= '0;
                    o2_q    <= '0;
                    d2_q[0] <= '0;
                    d2_q[1] <= '0;
                end else begin
                    v2_q <= v1_q;
                    for (int p = 0; p < 2; p++) begin
                        if (v1_q[p]) begin
                            d2_q[p] <= d1_q[p];
                            o2_q[p] <= o1_q[p];
                        end
                    end
                end
            end

            assign w_vo = v2_q;
            assign w_oo = o2_q;
            assign w_do = d2_q;
        end else begin : g_lat1
            assign w_vo = v1_q;
            assign w_oo = o1_q;
            assign w_do = d1_q;
        end
    endgenerate

    assign douta     = w_do[0];
    assign valida    = w_vo[0];
    assign oora      = w_vo[0] & w_oo[0];
    assign doutb     = w_do[1];
    assign validb    = w_vo[1];
    assign oorb      = w_vo[1] & w_oo[1];
    assign collision = collision_q;

`ifdef TDP_RAM_COLL_CNT_EN
    logic [15:0] cnt_d;
    logic [15:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (collision_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign coll_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_strb.sv
`default_nettype none
// Testbench for tdp_ram_strb: three instances (read-first/lat1, write-first/lat1,
// read-first/lat2) share one stimulus; directed vectors with hand-computed values.
module tb_tdp_ram_strb;

    logic        clk;
    logic        rst;
    logic        ena, enb;
    logic [3:0]  wena, wenb;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] da0, db0, da1, db1, da2, db2;
    logic        va0, vb0, oa0, ob0, col0;
    logic        va1, vb1, oa1, ob1, col1;
    logic        va2, vb2, oa2, ob2, col2;
`ifdef TDP_RAM_COLL_CNT_EN
    logic [15:0] cc0, cc1, cc2;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    tdp_ram_strb #(.DATA_WIDTH(32), .MEM_DEPTH(1000), .READ_LATENCY(1), .RDW_MODE(0)) u_rf (
        .clk(clk), .rst(rst),
        .ena(ena), .wena(wena), .addra(addra), .dina(dina), .douta(da0), .valida(va0), .oora(oa0),
        .enb(enb), .wenb(wenb), .addrb(addrb), .dinb(dinb), .doutb(db0), .validb(vb0), .oorb(ob0),
`ifdef TDP_RAM_COLL_CNT_EN
        .coll_cnt(cc0),
`endif
        .collision(col0));

    tdp_ram_strb #(.DATA_WIDTH(32), .MEM_DEPTH(1000), .READ_LATENCY(1), .RDW_MODE(1)) u_wf (
        .clk(clk), .rst(rst),
        .ena(ena), .wena(wena), .addra(addra), .dina(dina), .douta(da1), .valida(va1), .oora(oa1),
        .enb(enb), .wenb(wenb), .addrb(addrb), .dinb(dinb), .doutb(db1), .validb(vb1), .oorb(ob1),
`ifdef TDP_RAM_COLL_CNT_EN
        .coll_cnt(cc1),
`endif
        .collision(col1));

    tdp_ram_strb #(.DATA_WIDTH(32), .MEM_DEPTH(1000), .READ_LATENCY(2), .RDW_MODE(0)) u_l2 (
        .clk(clk), .rst(rst),
        .ena(ena), .wena(wena), .addra(addra), .dina(dina), .douta(da2), .valida(va2), .oora(oa2),
        .enb(enb), .wenb(wenb), .addrb(addrb), .dinb(dinb), .doutb(db2), .validb(vb2), .oorb(ob2),
`ifdef TDP_RAM_COLL_CNT_EN
        .coll_cnt(cc2),
`endif
        .collision(col2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv_a(input logic en, input logic [3:0] wen, input logic [9:0] addr, input logic [31:0] din);
        ena = en; wena = wen; addra = addr; dina = din;
    endtask

    task automatic drv_b(input logic en, input logic [3:0] wen, input logic [9:0] addr, input logic [31:0] din);
        enb = en; wenb = wen; addrb = addr; dinb = din;
    endtask

    task automatic idle();
        drv_a(1'b0, 4'h0, 10'd0, 32'h0);
        drv_b(1'b0, 4'h0, 10'd0, 32'h0);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #12;
        total_cnt++; if (va0 !== 1'b0)   $display("FAIL rst_valida: got %b want 0", va0); else pass_cnt++;
        total_cnt++; if (da0 !== 32'h0)  $display("FAIL rst_douta: got %h want 0", da0); else pass_cnt++;
        total_cnt++; if (oa0 !== 1'b0)   $display("FAIL rst_oora: got %b want 0", oa0); else pass_cnt++;
        total_cnt++; if (col0 !== 1'b0)  $display("FAIL rst_collision: got %b want 0", col0); else pass_cnt++;
        total_cnt++; if (vb2 !== 1'b0)   $display("FAIL rst_validb_l2: got %b want 0", vb2); else pass_cnt++;
        total_cnt++; if (db2 !== 32'h0)  $display("FAIL rst_doutb_l2: got %h want 0", db2); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
        edge_sample();
        total_cnt++; if (va0 !== 1'b1) $display("FAIL wr_valida: got %b want 1", va0); else pass_cnt++;
        total_cnt++; if (oa0 !== 1'b0) $display("FAIL wr_oora: got %b want 0", oa0); else pass_cnt++;
        total_cnt++; if (va2 !== 1'b0) $display("FAIL wr_valida_l2_early: got %b want 0", va2); else pass_cnt++;
        @(negedge clk); idle(); drv_b(1'b1, 4'h0, 10'd5, 32'h0);
        edge_sample();
        total_cnt++; if (vb0 !== 1'b1)         $display("FAIL rd_validb: got %b want 1", vb0); else pass_cnt++;
        total_cnt++; if (db0 !== 32'hDEADBEEF) $display("FAIL rd_doutb: got %h want deadbeef", db0); else pass_cnt++;
        total_cnt++; if (ob0 !== 1'b0)         $display("FAIL rd_oorb: got %b want 0", ob0); else pass_cnt++;
        total_cnt++; if (va0 !== 1'b0)         $display("FAIL rd_valida_drop: got %b want 0", va0); else pass_cnt++;
        total_cnt++; if (va2 !== 1'b1)         $display("FAIL wr_valida_l2: got %b want 1", va2); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
        total_cnt++; if (vb2 !== 1'b1)         $display("FAIL rd_validb_l2: got %b want 1", vb2); else pass_cnt++;
        total_cnt++; if (db2 !== 32'hDEADBEEF) $display("FAIL rd_doutb_l2: got %h want deadbeef", db2); else pass_cnt++;
        total_cnt++; if (vb0 !== 1'b0)         $display("FAIL rd_validb_drop: got %b want 0", vb0); else pass_cnt++;
        total_cnt++; if (db0 !== 32'hDEADBEEF) $display("FAIL rd_doutb_hold: got %h want deadbeef", db0); else pass_cnt++;
    endtask

    task automatic test_byte_strobe();
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd9, 32'h11223344);
        edge_sample();
        @(negedge clk); drv_a(1'b1, 4'b0101, 10'd9, 32'hAABBCCDD);
        edge_sample();
        total_cnt++; if (da0 !== 32'h11223344) $display("FAIL strb_rf_old: got %h want 11223344", da0); else pass_cnt++;
        total_cnt++; if (da1 !== 32'h11BB33DD) $display("FAIL strb_wf_new: got %h want 11bb33dd", da1); else pass_cnt++;
        @(negedge clk); idle(); drv_b(1'b1, 4'h0, 10'd9, 32'h0);
        edge_sample();
        total_cnt++; if (db0 !== 32'h11BB33DD) $display("FAIL strb_read: got %h want 11bb33dd", db0); else pass_cnt++;
    endtask

    task automatic test_rdw();
        @(negedge clk); idle(); drv_a(1'b1, 4'hF, 10'd3, 32'h0);
        edge_sample();
        @(negedge clk); idle();
        edge_sample();
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd3, 32'h55);
        edge_sample();
        total_cnt++; if (da0 !== 32'h0)  $display("FAIL rdw_read_first: got %h want 0", da0); else pass_cnt++;
        total_cnt++; if (da1 !== 32'h55) $display("FAIL rdw_write_first: got %h want 55", da1); else pass_cnt++;
        total_cnt++; if (va2 !== 1'b0)   $display("FAIL rdw_l2_early: got %b want 0", va2); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
        total_cnt++; if (va2 !== 1'b1)  $display("FAIL rdw_l2_valid: got %b want 1", va2); else pass_cnt++;
        total_cnt++; if (da2 !== 32'h0) $display("FAIL rdw_l2_data: got %h want 0", da2); else pass_cnt++;
        total_cnt++; if (va0 !== 1'b0)  $display("FAIL rdw_valid_pulse: got %b want 0", va0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd5, 32'h0);
        edge_sample();
        total_cnt++; if (da0 !== 32'hDEADBEEF) $display("FAIL b2b_first: got %h want deadbeef", da0); else pass_cnt++;
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd9, 32'h0);
        edge_sample();
        total_cnt++; if (va0 !== 1'b1 || da0 !== 32'h11BB33DD) $display("FAIL b2b_second: got %b/%h want 1/11bb33dd", va0, da0); else pass_cnt++;
        total_cnt++; if (va2 !== 1'b1 || da2 !== 32'hDEADBEEF) $display("FAIL b2b_l2_first: got %b/%h want 1/deadbeef", va2, da2); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
        total_cnt++; if (va2 !== 1'b1 || da2 !== 32'h11BB33DD) $display("FAIL b2b_l2_second: got %b/%h want 1/11bb33dd", va2, da2); else pass_cnt++;
        edge_sample();
        total_cnt++; if (va2 !== 1'b0 || da2 !== 32'h11BB33DD) $display("FAIL b2b_l2_hold: got %b/%h want 0/11bb33dd", va2, da2); else pass_cnt++;
    endtask

    task automatic test_collision();
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd7, 32'h0);
        edge_sample();
        @(negedge clk); idle();
        edge_sample();
        @(negedge clk); drv_a(1'b1, 4'b0011, 10'd7, 32'hAAAAAAAA); drv_b(1'b1, 4'b0110, 10'd7, 32'hBBBBBBBB);
        edge_sample();
        total_cnt++; if (col0 !== 1'b1)        $display("FAIL coll_ww: got %b want 1", col0); else pass_cnt++;
        total_cnt++; if (col2 !== 1'b1)        $display("FAIL coll_ww_l2: got %b want 1", col2); else pass_cnt++;
        total_cnt++; if (db0 !== 32'h0)        $display("FAIL coll_ww_rf_b: got %h want 0", db0); else pass_cnt++;
        total_cnt++; if (db1 !== 32'h00BBAAAA) $display("FAIL coll_ww_wf_b: got %h want 00bbaaaa", db1); else pass_cnt++;
        total_cnt++; if (da1 !== 32'h00BBAAAA) $display("FAIL coll_ww_wf_a: got %h want 00bbaaaa", da1); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
        total_cnt++; if (col0 !== 1'b0) $display("FAIL coll_pulse: got %b want 0", col0); else pass_cnt++;
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd7, 32'h0);
        edge_sample();
        total_cnt++; if (da0 !== 32'h00BBAAAA) $display("FAIL coll_merge: got %h want 00bbaaaa", da0); else pass_cnt++;
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd7, 32'h12345678); drv_b(1'b1, 4'h0, 10'd7, 32'h0);
        edge_sample();
        total_cnt++; if (col0 !== 1'b1)        $display("FAIL coll_rw: got %b want 1", col0); else pass_cnt++;
        total_cnt++; if (db1 !== 32'h00BBAAAA) $display("FAIL coll_rw_reader_old: got %h want 00bbaaaa", db1); else pass_cnt++;
        total_cnt++; if (da1 !== 32'h12345678) $display("FAIL coll_rw_writer_new: got %h want 12345678", da1); else pass_cnt++;
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd7, 32'h0); drv_b(1'b1, 4'h0, 10'd7, 32'h0);
        edge_sample();
        total_cnt++; if (col0 !== 1'b0)        $display("FAIL coll_rr: got %b want 0", col0); else pass_cnt++;
        total_cnt++; if (da0 !== 32'h12345678) $display("FAIL coll_rr_data: got %h want 12345678", da0); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
`ifdef TDP_RAM_COLL_CNT_EN
        total_cnt++; if (cc0 !== 16'd2) $display("FAIL coll_cnt: got %0d want 2", cc0); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd5, 32'h0);
        edge_sample();
        rst = 1'b0;
        #1;
        total_cnt++; if (va2 !== 1'b0) $display("FAIL mid_valid_l2: got %b want 0", va2); else pass_cnt++;
        total_cnt++; if (da2 !== 32'h0) $display("FAIL mid_dout_l2: got %h want 0", da2); else pass_cnt++;
        total_cnt++; if (va0 !== 1'b0 || da0 !== 32'h0) $display("FAIL mid_rf_out: got %b/%h want 0/0", va0, da0); else pass_cnt++;
`ifdef TDP_RAM_COLL_CNT_EN
        total_cnt++; if (cc0 !== 16'd0) $display("FAIL mid_coll_cnt: got %0d want 0", cc0); else pass_cnt++;
`endif
        @(negedge clk); idle();
        @(negedge clk); rst = 1'b1;
        edge_sample();
        total_cnt++; if (va2 !== 1'b0) $display("FAIL mid_no_valid_1: got %b want 0", va2); else pass_cnt++;
        edge_sample();
        total_cnt++; if (va2 !== 1'b0) $display("FAIL mid_no_valid_2: got %b want 0", va2); else pass_cnt++;
        @(negedge clk); drv_a(1'b1, 4'h0, 10'd5, 32'h0);
        edge_sample();
        total_cnt++; if (da0 !== 32'hDEADBEEF) $display("FAIL mid_mem_persist: got %h want deadbeef", da0); else pass_cnt++;
        @(negedge clk); idle();
    endtask

    task automatic test_oor();
        @(negedge clk); drv_a(1'b1, 4'hF, 10'd1000, 32'h12345678); drv_b(1'b1, 4'hF, 10'd1000, 32'h87654321);
        edge_sample();
        total_cnt++; if (col0 !== 1'b0) $display("FAIL oor_no_coll: got %b want 0", col0); else pass_cnt++;
        total_cnt++; if (va0 !== 1'b1 || oa0 !== 1'b1 || da0 !== 32'h0) $display("FAIL oor_a: got %b/%b/%h want 1/1/0", va0, oa0, da0); else pass_cnt++;
        total_cnt++; if (vb0 !== 1'b1 || ob0 !== 1'b1 || db0 !== 32'h0) $display("FAIL oor_b: got %b/%b/%h want 1/1/0", vb0, ob0, db0); else pass_cnt++;
        total_cnt++; if (da1 !== 32'h0) $display("FAIL oor_wf: got %h want 0", da1); else pass_cnt++;
        @(negedge clk); idle(); drv_a(1'b1, 4'h0, 10'd1000, 32'h0);
        edge_sample();
        total_cnt++; if (oa0 !== 1'b1 || da0 !== 32'h0) $display("FAIL oor_read: got %b/%h want 1/0", oa0, da0); else pass_cnt++;
        @(negedge clk); idle();
        edge_sample();
        total_cnt++; if (oa0 !== 1'b0) $display("FAIL oor_aligned: got %b want 0", oa0); else pass_cnt++;
        total_cnt++; if (oa2 !== 1'b1 || va2 !== 1'b1) $display("FAIL oor_l2: got %b/%b want 1/1", oa2, va2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_rdw();
        test_back_to_back();
        test_collision();
        test_reset_midflight();
        test_oor();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdp_ram_strb.md
Name: tdp_ram_strb

Overview:
- Parametrised true dual-port RAM and successor to the simple dual-port RAM.
- Two fully symmetric ports (A, B), each able to read or byte-strobe-write in any cycle, on one clock.
- Adds selectable read latency, a read-during-write mode, out-of-range address protection and write-collision arbitration/flagging.
- Used as shared buffer memory between two masters in the same clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 1024, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- STRB_WIDTH, DATA_WIDTH/8, byte write-enable width.
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, 0, same-port read-during-write result: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- ena  in  1  port A request enable.
- wena  in  STRB_WIDTH  port A byte write strobes; all-zero with ena=1 means read.
- addra  in  ADDR_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- valida  out  1  port A read data valid.
- oora  out  1  port A out-of-range flag, aligned with valida.
- enb, wenb, addrb, dinb, doutb, validb, oorb: port B equivalents, same widths and directions.
- collision  out  1  single-cycle pulse: both ports accessed the same address in one cycle with at least one writing.

Behaviour:
- Reset (rst=0, asynchronous): douta, doutb, valida, validb, oora, oorb and collision clear to 0; the output pipeline is flushed.
- Memory array is not reset; contents persist across reset.
- Request: ena=1 on rising edge. Any bit of wena set = write of the strobed bytes only; unstrobed bytes keep their stored value.
- Every accepted request (read or write) returns read data: valida asserts exactly READ_LATENCY cycles after the request, for one cycle per request. Back-to-back requests give back-to-back valids.
- When valida=0, douta holds its last value.
- Same-port write data returned: RDW_MODE=0 returns pre-write contents; RDW_MODE=1 returns the merged post-write word.
- Out of range (addr >= MEM_DEPTH): write suppressed, memory untouched; returned data = 0 with oora=1 alongside valida.
- Cross-port, same address, same cycle:
  - A write + B write: port A wins on bytes strobed by both; bytes strobed by only one port take that port's data.
  - One writes, other reads: reader gets the old data, regardless of RDW_MODE.
  - collision pulses 1 cycle after the request edge, independent of READ_LATENCY.
- Two reads to the same address: no collision.
- Out-of-range requests never raise collision.
- Reset asserted mid-operation: in-flight reads are discarded with no valid afterwards. A write sampled on an edge before reset asserted is committed.
- No backpressure: both ports accept every cycle.

Optional Feature:
- Macro: TDP_RAM_COLL_CNT_EN.
- Defined: adds output coll_cnt (16 bits). It increments on every collision pulse, saturates at 16'hFFFF, and is cleared by rst.
- Not defined: no port, no counter logic. collision is still present.

Test Plan:
- Write/read, READ_LATENCY=1: A writes 0xDEADBEEF to addr 5 with wena=4'hF; next cycle B reads addr 5 -> validb one cycle later, doutb=0xDEADBEEF, oorb=0.
- Byte strobes: A writes 0x11223344 to addr 9 (4'hF), then 0xAABBCCDD with wena=4'b0101; read addr 9 -> 0x11BB33DD.
- RDW mode, addr 3 holding 0x0, A writes 0x55 with a same-port read:
  - RDW_MODE=0 -> douta=0x0.
  - RDW_MODE=1 -> douta=0x55.
  - READ_LATENCY=2 -> valida arrives 2 cycles after the request.
- Dual write collision: A writes 0xAAAAAAAA (4'b0011) and B writes 0xBBBBBBBB (4'b0110) to addr 7 in the same cycle -> collision=1 for one cycle; later read -> 0x00BBAAAA, given prior contents 0.
- Out of range, MEM_DEPTH=1000: write to addr 1000 -> memory unchanged; read addr 1000 -> dout=0, oor=1; no collision when both ports target 1000.
- Reset mid-flight: READ_LATENCY=2, read issued, rst low for 1 cycle before data -> valid never asserts, outputs 0; with TDP_RAM_COLL_CNT_EN, coll_cnt reads 0 after reset.
